// File: rtl/mem_stream_reader.sv
// Read-side streaming master for the byte-packed operand memory: fetches a run of
// consecutive words and emits each one MSB byte first over a valid/ready handshake.
module mem_stream_reader #(
    parameter int WORD_W = 128,
    parameter int BYTE_W = 8,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] baseAddr,
    input  logic [ADDR_W-1:0] wordCount,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] readPtr,
    input  logic [WORD_W-1:0] rdData,
    output logic [BYTE_W-1:0] outData,
    output logic              outValid,
    input  logic              outReady,
    output logic              lastByte
);

    localparam int NBYTES = WORD_W / BYTE_W;
    localparam int CNT_W  = $clog2(NBYTES);
    localparam logic [CNT_W-1:0] LAST_IDX   = CNT_W'(NBYTES - 1);
    localparam logic [CNT_W-1:0] PENULT_IDX = CNT_W'(NBYTES - 2);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_LOAD = 3'd2,
        S_SEND = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [ADDR_W-1:0]  r_addr;
    logic [ADDR_W-1:0]  r_remaining;
    logic [ADDR_W-1:0]  r_read_ptr;
    logic [WORD_W-1:0]  r_shift;
    logic [CNT_W-1:0]   r_byte_cnt;
    logic               r_out_valid;
    logic               r_last_byte;
    logic               r_busy;
    logic               r_done;
    logic               w_busy_nxt;
    logic               w_done_nxt;
    logic               w_xfer;
    logic               w_word_end;

    assign w_xfer     = r_out_valid & outReady;
    assign w_word_end = w_xfer && (r_byte_cnt == LAST_IDX);

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (wordCount == {ADDR_W{1'b0}}) begin
                        w_next_state = S_DONE;
                    end else begin
                        w_next_state = S_REQ;
                    end
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_REQ:  w_next_state = S_LOAD;
            S_LOAD: w_next_state = S_SEND;
            S_SEND: begin
                if (w_word_end) begin
                    if (r_remaining > ADDR_W'(1)) begin
                        w_next_state = S_REQ;
                    end else begin
                        w_next_state = S_DONE;
                    end
                end else begin
                    w_next_state = S_SEND;
                end
            end
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Status outputs decoded from the state being entered, so they register cleanly
    always_comb begin
        w_busy_nxt = 1'b0;
        w_done_nxt = 1'b0;
        case (w_next_state)
            S_REQ, S_LOAD, S_SEND: w_busy_nxt = 1'b1;
            S_DONE:                w_done_nxt = 1'b1;
            default: begin
                w_busy_nxt = 1'b0;
                w_done_nxt = 1'b0;
            end
        endcase
    end

    // Status output registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_busy <= w_busy_nxt;
            r_done <= w_done_nxt;
        end
    end

    // Address, word shifter and byte handshake datapath
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_addr      <= {ADDR_W{1'b0}};
            r_remaining <= {ADDR_W{1'b0}};
            r_read_ptr  <= {ADDR_W{1'b0}};
            r_shift     <= {WORD_W{1'b0}};
            r_byte_cnt  <= {CNT_W{1'b0}};
            r_out_valid <= 1'b0;
            r_last_byte <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_addr      <= baseAddr;
                        r_remaining <= wordCount;
                        if (wordCount != {ADDR_W{1'b0}}) begin
                            r_read_ptr <= baseAddr;
                        end
                    end
                end
                S_LOAD: begin
                    r_shift     <= rdData;
                    r_byte_cnt  <= {CNT_W{1'b0}};
                    r_out_valid <= 1'b1;
                    r_last_byte <= 1'b0;
                end
                S_SEND: begin
                    if (w_word_end) begin
                        r_out_valid <= 1'b0;
                        r_last_byte <= 1'b0;
                        r_remaining <= r_remaining - ADDR_W'(1);
                        if (r_remaining > ADDR_W'(1)) begin
                            r_addr     <= r_addr + ADDR_W'(1);
                            r_read_ptr <= r_addr + ADDR_W'(1);
                        end
                    end else if (w_xfer) begin
                        // lastByte rises with the final byte of the final word only
                        r_shift     <= r_shift << BYTE_W;
                        r_byte_cnt  <= r_byte_cnt + CNT_W'(1);
                        r_last_byte <= (r_byte_cnt == PENULT_IDX) && (r_remaining == ADDR_W'(1));
                    end
                end
                S_REQ, S_DONE: begin
                    r_out_valid <= 1'b0;
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_last_byte <= 1'b0;
                end
            endcase
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign readPtr  = r_read_ptr;
    assign outData  = r_shift[WORD_W-1 -: BYTE_W];
    assign outValid = r_out_valid;
    assign lastByte = r_last_byte;

endmodule

// File: tb/tb_mem_stream_reader.sv
// Bench for mem_stream_reader: 64x128 registered-read memory model, negedge monitor,
// and a word-list reference model of the expected byte stream and read addresses.
module tb_mem_stream_reader;

    logic         clk, reset, start, busy, done, outValid, outReady, lastByte;
    logic [15:0]  baseAddr, wordCount, readPtr;
    logic [127:0] rdData;
    logic [7:0]   outData;
    logic [127:0] mem [64];

    int n_cmp = 0;
    int n_fail = 0;

    bit   mon_en;
    int   cyc, valid_cnt, done_cnt, done_cyc, stall_err, last_err, busy_err;
    logic busy_c1, prev_valid, prev_ready;
    logic [7:0]  prev_data;
    logic [7:0]  got_q[$];
    bit          last_q[$];
    int          xcyc_q[$];
    logic [15:0] ptr_q[$];
    logic [7:0]  exp_q[$];
    logic [15:0] exp_ptr_q[$];

    mem_stream_reader dut (
        .clk(clk), .reset(reset), .start(start), .baseAddr(baseAddr), .wordCount(wordCount),
        .busy(busy), .done(done), .readPtr(readPtr), .rdData(rdData), .outData(outData),
        .outValid(outValid), .outReady(outReady), .lastByte(lastByte)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) rdData <= mem[readPtr[5:0]];

    // Monitor: samples away from the active edge and records transfers and protocol errors
    always @(negedge clk) begin
        if (mon_en) begin
            cyc++;
            if (outValid === 1'b1 && outReady === 1'b1) begin
                got_q.push_back(outData);
                last_q.push_back(lastByte);
                xcyc_q.push_back(cyc);
            end
            if (outValid === 1'b1 && prev_valid !== 1'b1) ptr_q.push_back(readPtr);
            if (outValid === 1'b1) valid_cnt++;
            if (lastByte === 1'b1 && outValid !== 1'b1) last_err++;
            if (cyc == 1) busy_c1 = busy;
            if (done === 1'b1) begin
                done_cnt++;
                done_cyc = cyc;
                if (busy !== 1'b0) busy_err++;
            end
            if (prev_valid === 1'b1 && prev_ready !== 1'b1 && (outValid !== 1'b1 || outData !== prev_data))
                stall_err++;
            prev_valid = outValid;
            prev_ready = outReady;
            prev_data  = outData;
        end
    end

    task automatic clear_mon();
        got_q.delete(); last_q.delete(); xcyc_q.delete(); ptr_q.delete();
        cyc = 0; valid_cnt = 0; done_cnt = 0; done_cyc = -1;
        stall_err = 0; last_err = 0; busy_err = 0; busy_c1 = 1'b0;
        prev_valid = 1'b0; prev_ready = 1'b0; prev_data = 8'h00;
    endtask

    // Reference: a run is the listed words, each split into bytes most-significant first
    task automatic model_run(input logic [15:0] base, input logic [15:0] cnt);
        logic [15:0]  a;
        logic [127:0] w;
        exp_q.delete(); exp_ptr_q.delete();
        for (int i = 0; i < int'(cnt); i++) begin
            a = base + 16'(i);
            exp_ptr_q.push_back(a);
            w = mem[a[5:0]];
            for (int b = 0; b < 16; b++) exp_q.push_back(w[127-8*b -: 8]);
        end
    endtask

    // rmode: 0 ready always, 1 ready pattern 1,0,0, 2 random ready
    task automatic do_run(input logic [15:0] base, input logic [15:0] cnt, input int rmode,
                          input bit midstart, output bit timed_out);
        clear_mon();
        baseAddr = base; wordCount = cnt; start = 1'b1; outReady = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; cyc = 0; mon_en = 1'b1;
        timed_out = 1'b1;
        for (int c = 1; c < 2000; c++) begin
            case (rmode)
                0:       outReady = 1'b1;
                1:       outReady = (c % 3 == 1);
                default: outReady = 1'($urandom_range(0, 1));
            endcase
            if (midstart && c == 10) begin
                start = 1'b1; baseAddr = 16'($urandom); wordCount = 16'($urandom_range(1, 5));
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            if (done_cnt > 0) begin
                timed_out = 1'b0;
                break;
            end
        end
        start = 1'b0; outReady = 1'b1;
        repeat (4) @(posedge clk);
        #1 mon_en = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b1; baseAddr = 16'h1234; wordCount = 16'd2; outReady = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (outValid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b expected 0", outValid); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b expected 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b expected 0", done); end
        n_cmp++; if (lastByte !== 1'b0) begin n_fail++; $display("FAIL rst_last: got %b expected 0", lastByte); end
        n_cmp++; if (outData !== 8'h00) begin n_fail++; $display("FAIL rst_data: got %h expected 00", outData); end
        n_cmp++; if (readPtr !== 16'h0000) begin n_fail++; $display("FAIL rst_ptr: got %h expected 0000", readPtr); end
        reset = 1'b1; start = 1'b0;
        @(posedge clk); #1;
        n_cmp++; if (busy !== 1'b0 || readPtr !== 16'h0000)
            begin n_fail++; $display("FAIL rst_idle: got busy=%b ptr=%h expected busy=0 ptr=0000", busy, readPtr); end
    endtask

    task automatic test_single_word();
        bit tmo;
        mem[3] = 128'h00112233_44556677_8899AABB_CCDDEEFF;
        do_run(16'd3, 16'd1, 0, 1'b0, tmo);
        n_cmp++; if (tmo) begin n_fail++; $display("FAIL single_timeout: got no done expected done"); end
        n_cmp++; if (got_q.size() != 16) begin n_fail++; $display("FAIL single_len: got %0d expected 16", got_q.size()); end
        else for (int i = 0; i < 16; i++) begin
            n_cmp++; if (got_q[i] !== 8'(i * 17) || xcyc_q[i] != 3 + i || last_q[i] != (i == 15))
                begin n_fail++; $display("FAIL single_byte%0d: got %h@%0d last=%b expected %h@%0d last=%b",
                      i, got_q[i], xcyc_q[i], last_q[i], 8'(i * 17), 3 + i, i == 15); end
        end
        n_cmp++; if (ptr_q.size() != 1 || ptr_q[0] !== 16'd3)
            begin n_fail++; $display("FAIL single_ptr: got n=%0d first=%h expected n=1 0003", ptr_q.size(), ptr_q[0]); end
        n_cmp++; if (done_cnt != 1 || done_cyc != 19)
            begin n_fail++; $display("FAIL single_done: got n=%0d cyc=%0d expected n=1 cyc=19", done_cnt, done_cyc); end
        n_cmp++; if (busy_c1 !== 1'b1 || busy_err != 0 || last_err != 0)
            begin n_fail++; $display("FAIL single_flags: got busy1=%b busyerr=%0d lasterr=%0d expected 1 0 0",
                  busy_c1, busy_err, last_err); end
    endtask

    task automatic test_backpressure();
        bit tmo;
        do_run(16'd3, 16'd1, 1, 1'b0, tmo);
        n_cmp++; if (tmo) begin n_fail++; $display("FAIL bp_timeout: got no done expected done"); end
        n_cmp++; if (got_q.size() != 16) begin n_fail++; $display("FAIL bp_len: got %0d expected 16", got_q.size()); end
        else for (int i = 0; i < 16; i++) begin
            n_cmp++; if (got_q[i] !== 8'(i * 17) || last_q[i] != (i == 15))
                begin n_fail++; $display("FAIL bp_byte%0d: got %h last=%b expected %h last=%b",
                      i, got_q[i], last_q[i], 8'(i * 17), i == 15); end
        end
        n_cmp++; if (stall_err != 0) begin n_fail++; $display("FAIL bp_stall: got %0d unstable stalls expected 0", stall_err); end
        n_cmp++; if (done_cnt != 1) begin n_fail++; $display("FAIL bp_done: got %0d expected 1", done_cnt); end
    endtask

    task automatic test_multi_wrap();
        bit tmo;
        model_run(16'hFFFF, 16'd3);
        do_run(16'hFFFF, 16'd3, 0, 1'b0, tmo);
        n_cmp++; if (tmo) begin n_fail++; $display("FAIL wrap_timeout: got no done expected done"); end
        n_cmp++; if (ptr_q.size() != 3) begin n_fail++; $display("FAIL wrap_nptr: got %0d expected 3", ptr_q.size()); end
        else for (int w = 0; w < 3; w++) begin
            n_cmp++; if (ptr_q[w] !== exp_ptr_q[w])
                begin n_fail++; $display("FAIL wrap_ptr%0d: got %h expected %h", w, ptr_q[w], exp_ptr_q[w]); end
        end
        n_cmp++; if (got_q.size() != 48) begin n_fail++; $display("FAIL wrap_len: got %0d expected 48", got_q.size()); end
        else for (int k = 0; k < 48; k++) begin
            n_cmp++; if (got_q[k] !== exp_q[k] || xcyc_q[k] != 3 + (k / 16) * 18 + (k % 16) || last_q[k] != (k == 47))
                begin n_fail++; $display("FAIL wrap_byte%0d: got %h@%0d last=%b expected %h@%0d last=%b", k,
                      got_q[k], xcyc_q[k], last_q[k], exp_q[k], 3 + (k / 16) * 18 + (k % 16), k == 47); end
        end
        n_cmp++; if (done_cnt != 1 || done_cyc != 55)
            begin n_fail++; $display("FAIL wrap_done: got n=%0d cyc=%0d expected n=1 cyc=55", done_cnt, done_cyc); end
    endtask

    task automatic test_zero_count();
        bit tmo;
        do_run(16'h0020, 16'd0, 0, 1'b0, tmo);
        n_cmp++; if (tmo) begin n_fail++; $display("FAIL zero_timeout: got no done expected done"); end
        n_cmp++; if (done_cnt != 1 || done_cyc != 1)
            begin n_fail++; $display("FAIL zero_done: got n=%0d cyc=%0d expected n=1 cyc=1", done_cnt, done_cyc); end
        n_cmp++; if (valid_cnt != 0) begin n_fail++; $display("FAIL zero_valid: got %0d valid cycles expected 0", valid_cnt); end
    endtask

    task automatic test_start_while_busy();
        bit tmo;
        logic [15:0] base;
        base = 16'($urandom);
        model_run(base, 16'd2);
        do_run(base, 16'd2, 0, 1'b1, tmo);
        n_cmp++; if (tmo) begin n_fail++; $display("FAIL busy_timeout: got no done expected done"); end
        n_cmp++; if (got_q.size() != 32) begin n_fail++; $display("FAIL busy_len: got %0d expected 32", got_q.size()); end
        else for (int k = 0; k < 32; k++) begin
            n_cmp++; if (got_q[k] !== exp_q[k])
                begin n_fail++; $display("FAIL busy_byte%0d: got %h expected %h", k, got_q[k], exp_q[k]); end
        end
        n_cmp++; if (done_cnt != 1) begin n_fail++; $display("FAIL busy_done: got %0d expected 1", done_cnt); end
    endtask

    task automatic test_random_runs();
        bit tmo;
        logic [15:0] base, cnt;
        for (int r = 0; r < 6; r++) begin
            base = 16'($urandom); cnt = 16'($urandom_range(1, 4));
            model_run(base, cnt);
            do_run(base, cnt, 2, 1'b0, tmo);
            n_cmp++; if (tmo) begin n_fail++; $display("FAIL rnd%0d_timeout: got no done expected done", r); end
            n_cmp++; if (got_q.size() != exp_q.size())
                begin n_fail++; $display("FAIL rnd%0d_len: got %0d expected %0d", r, got_q.size(), exp_q.size()); end
            else for (int k = 0; k < exp_q.size(); k++) begin
                n_cmp++; if (got_q[k] !== exp_q[k] || last_q[k] != (k == exp_q.size() - 1))
                    begin n_fail++; $display("FAIL rnd%0d_byte%0d: got %h last=%b expected %h last=%b", r, k,
                          got_q[k], last_q[k], exp_q[k], k == exp_q.size() - 1); end
            end
            n_cmp++; if (ptr_q != exp_ptr_q)
                begin n_fail++; $display("FAIL rnd%0d_ptr: got n=%0d expected n=%0d", r, ptr_q.size(), exp_ptr_q.size()); end
            n_cmp++; if (stall_err != 0 || last_err != 0 || done_cnt != 1)
                begin n_fail++; $display("FAIL rnd%0d_proto: got stall=%0d last=%0d done=%0d expected 0 0 1",
                      r, stall_err, last_err, done_cnt); end
        end
    endtask

    task automatic test_reset_mid_send();
        bit hit, tmo;
        logic [15:0] base;
        hit = 1'b0;
        clear_mon();
        baseAddr = 16'h0010; wordCount = 16'd2; start = 1'b1; outReady = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; cyc = 0; mon_en = 1'b1;
        for (int c = 0; c < 60; c++) begin
            @(posedge clk); #1;
            if (got_q.size() >= 5) begin hit = 1'b1; break; end
        end
        n_cmp++; if (!hit) begin n_fail++; $display("FAIL mid_reach: got %0d bytes expected 5", got_q.size()); end
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        n_cmp++; if (outValid !== 1'b0 || busy !== 1'b0)
            begin n_fail++; $display("FAIL mid_abort: got valid=%b busy=%b expected 0 0", outValid, busy); end
        clear_mon();
        repeat (20) @(posedge clk);
        #1 mon_en = 1'b0;
        n_cmp++; if (done_cnt != 0 || valid_cnt != 0)
            begin n_fail++; $display("FAIL mid_quiet: got done=%0d valid=%0d expected 0 0", done_cnt, valid_cnt); end
        base = 16'($urandom);
        model_run(base, 16'd1);
        do_run(base, 16'd1, 0, 1'b0, tmo);
        n_cmp++; if (tmo || got_q.size() != 16 || done_cnt != 1)
            begin n_fail++; $display("FAIL mid_rerun: got tmo=%b len=%0d done=%0d expected 0 16 1",
                  tmo, got_q.size(), done_cnt); end
        else for (int k = 0; k < 16; k++) begin
            n_cmp++; if (got_q[k] !== exp_q[k])
                begin n_fail++; $display("FAIL mid_byte%0d: got %h expected %h", k, got_q[k], exp_q[k]); end
        end
    endtask

    initial begin
        mon_en = 1'b0; reset = 1'b0; start = 1'b0; outReady = 1'b0;
        baseAddr = 16'h0000; wordCount = 16'h0000;
        clear_mon();
        for (int i = 0; i < 64; i++) mem[i] = {$urandom, $urandom, $urandom, $urandom};
        @(posedge clk); #1;
        test_reset();
        test_single_word();
        test_backpressure();
        test_multi_wrap();
        test_zero_count();
        test_start_while_busy();
        test_random_runs();
        test_reset_mid_send();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
